// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, ALU op codes
// and the packed EX/MEM/WB control bundle carried by ID/EX.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
    } ex_ctrl_t;

    // All-zero control: an inert bubble that writes nothing and touches no memory.
    localparam ex_ctrl_t EX_CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector. Purely combinational: flags an ID instruction
// that reads the destination of a load currently in EX and derives the
// PC / IF-ID write enables from it.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              hold,
    input  logic              flush,
    input  logic              valid_ex,
    input  logic              memRead_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              valid_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    output logic              load_use,
    output logic              pc_write,
    output logic              if_id_write
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_stall;

    // Dependency test against the load in EX; a load into $0 never produces a value.
    always_comb begin
        w_rs_match  = use_rs_id & (rs_id == rd_ex);
        w_rt_match  = use_rt_id & (rt_id == rd_ex);
        load_use    = valid_ex & memRead_ex & (|rd_ex) & valid_id & (w_rs_match | w_rt_match);
        // A flushed ID instruction is killed anyway, so it must not freeze fetch.
        w_stall     = load_use & ~flush;
        pc_write    = ~w_stall & ~hold;
        if_id_write = ~w_stall & ~hold;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating
// stall/flush event counters for performance debug.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int REG_AW  = pipe_pkg::REG_AW,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               valid_id,
    input  logic [REG_AW-1:0]  rs_id,
    input  logic [REG_AW-1:0]  rt_id,
    input  logic [REG_AW-1:0]  rd_id,
    input  logic               use_rs_id,
    input  logic               use_rt_id,
    input  logic [DATA_W-1:0]  rdata_a_id,
    input  logic [DATA_W-1:0]  rdata_b_id,
    input  logic [DATA_W-1:0]  imm_id,
    input  logic               regWrite_id,
    input  logic               memRead_id,
    input  logic               memWrite_id,
    input  logic               memToReg_id,
    input  logic               aluSrc_id,
    input  logic [ALUOP_W-1:0] aluOp_id,
    output logic [REG_AW-1:0]  rs_ex,
    output logic [REG_AW-1:0]  rt_ex,
    output logic [REG_AW-1:0]  rd_ex,
    output logic [DATA_W-1:0]  rdata_a_ex,
    output logic [DATA_W-1:0]  rdata_b_ex,
    output logic [DATA_W-1:0]  imm_ex,
    output logic               regWrite_ex,
    output logic               memRead_ex,
    output logic               memWrite_ex,
    output logic               memToReg_ex,
    output logic               aluSrc_ex,
    output logic [ALUOP_W-1:0] aluOp_ex,
    output logic               valid_ex,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic [DATA_W-1:0] r_imm;
    ex_ctrl_t          r_ctrl;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    ex_ctrl_t          w_ctrl_id;
    logic              w_load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Bundle the incoming control bits so a bubble is a single NOP assignment.
    always_comb begin
        w_ctrl_id          = EX_CTRL_NOP;
        w_ctrl_id.regWrite = regWrite_id;
        w_ctrl_id.memRead  = memRead_id;
        w_ctrl_id.memWrite = memWrite_id;
        w_ctrl_id.memToReg = memToReg_id;
        w_ctrl_id.aluSrc   = aluSrc_id;
        w_ctrl_id.aluOp    = aluOp_id;
    end

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .hold        (hold),
        .flush       (flush),
        .valid_ex    (r_valid),
        .memRead_ex  (r_ctrl.memRead),
        .rd_ex       (r_rd),
        .valid_id    (valid_id),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .use_rs_id   (use_rs_id),
        .use_rt_id   (use_rt_id),
        .load_use    (w_load_use),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    // ID -> EX register: reset, then hold, then flush bubble, then load-use bubble, else capture ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
            r_imm       <= '0;
            r_ctrl      <= EX_CTRL_NOP;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            if (flush || w_load_use) begin
                // Zero indices so the forwarding unit can never match a bubble.
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_rdata_a <= '0;
                r_rdata_b <= '0;
                r_imm     <= '0;
                r_ctrl    <= EX_CTRL_NOP;
                r_valid   <= 1'b0;
                if (flush)
                    r_flush_cnt <= sat_inc(r_flush_cnt);
                else
                    r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_rs      <= rs_id;
                r_rt      <= rt_id;
                r_rd      <= rd_id;
                r_rdata_a <= rdata_a_id;
                r_rdata_b <= rdata_b_id;
                r_imm     <= imm_id;
                r_ctrl    <= w_ctrl_id;
                r_valid   <= valid_id;
            end
        end
    end

    assign rs_ex       = r_rs;
    assign rt_ex       = r_rt;
    assign rd_ex       = r_rd;
    assign rdata_a_ex  = r_rdata_a;
    assign rdata_b_ex  = r_rdata_b;
    assign imm_ex      = r_imm;
    assign regWrite_ex = r_ctrl.regWrite;
    assign memRead_ex  = r_ctrl.memRead;
    assign memWrite_ex = r_ctrl.memWrite;
    assign memToReg_ex = r_ctrl.memToReg;
    assign aluSrc_ex   = r_ctrl.aluSrc;
    assign aluOp_ex    = r_ctrl.aluOp;
    assign valid_ex    = r_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver feeds directed and random
// instructions, a reference model predicts EX contents, write enables and
// event counts; monitors compare against the DUT. A second instance with
// 2-bit counters exposes saturation quickly.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OW  = 4;
    localparam int CW  = 16;
    localparam int CWS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, hold, flush, valid_id, use_rs_id, use_rt_id;
    logic [AW-1:0] rs_id, rt_id, rd_id;
    logic [DW-1:0] rdata_a_id, rdata_b_id, imm_id;
    logic          regWrite_id, memRead_id, memWrite_id, memToReg_id, aluSrc_id;
    logic [OW-1:0] aluOp_id;

    logic [AW-1:0] rs_ex, rt_ex, rd_ex;
    logic [DW-1:0] rdata_a_ex, rdata_b_ex, imm_ex;
    logic          regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex, aluSrc_ex;
    logic [OW-1:0] aluOp_ex;
    logic          valid_ex, pc_write, if_id_write;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic [AW-1:0] s_rs_ex, s_rt_ex, s_rd_ex;
    logic [DW-1:0] s_rdata_a_ex, s_rdata_b_ex, s_imm_ex;
    logic          s_regWrite_ex, s_memRead_ex, s_memWrite_ex, s_memToReg_ex, s_aluSrc_ex;
    logic [OW-1:0] s_aluOp_ex;
    logic          s_valid_ex, s_pc_write, s_if_id_write;
    logic [CWS-1:0] s_stall_cnt, s_flush_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .valid_id(valid_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rdata_a_id(rdata_a_id), .rdata_b_id(rdata_b_id), .imm_id(imm_id),
        .regWrite_id(regWrite_id), .memRead_id(memRead_id), .memWrite_id(memWrite_id),
        .memToReg_id(memToReg_id), .aluSrc_id(aluSrc_id), .aluOp_id(aluOp_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .rdata_a_ex(rdata_a_ex), .rdata_b_ex(rdata_b_ex), .imm_ex(imm_ex),
        .regWrite_ex(regWrite_ex), .memRead_ex(memRead_ex), .memWrite_ex(memWrite_ex),
        .memToReg_ex(memToReg_ex), .aluSrc_ex(aluSrc_ex), .aluOp_ex(aluOp_ex),
        .valid_ex(valid_ex), .pc_write(pc_write), .if_id_write(if_id_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CWS)) dut_small (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .valid_id(valid_id),
        .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rdata_a_id(rdata_a_id), .rdata_b_id(rdata_b_id), .imm_id(imm_id),
        .regWrite_id(regWrite_id), .memRead_id(memRead_id), .memWrite_id(memWrite_id),
        .memToReg_id(memToReg_id), .aluSrc_id(aluSrc_id), .aluOp_id(aluOp_id),
        .rs_ex(s_rs_ex), .rt_ex(s_rt_ex), .rd_ex(s_rd_ex),
        .rdata_a_ex(s_rdata_a_ex), .rdata_b_ex(s_rdata_b_ex), .imm_ex(s_imm_ex),
        .regWrite_ex(s_regWrite_ex), .memRead_ex(s_memRead_ex), .memWrite_ex(s_memWrite_ex),
        .memToReg_ex(s_memToReg_ex), .aluSrc_ex(s_aluSrc_ex), .aluOp_ex(s_aluOp_ex),
        .valid_ex(s_valid_ex), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic          reset, hold, flush, valid;
        logic [AW-1:0] rs, rt, rd;
        logic          use_rs, use_rt;
        logic [DW-1:0] a, b, imm;
        logic          rw, mr, mw, m2r, asrc;
        logic [OW-1:0] op;
    } stim_t;

    // What EX should hold: an instruction record plus a valid flag.
    typedef struct packed {
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic          rw, mr, mw, m2r, asrc;
        logic [OW-1:0] op;
        logic          v;
    } exrec_t;

    typedef struct packed {
        logic [CW-1:0]  sc, fc;
        logic [CWS-1:0] sc2, fc2;
    } cnt_t;

    exrec_t q_ex[$];
    cnt_t   q_cnt[$];
    string  q_tag[$];
    logic   q_pcw[$];
    string  q_ctag[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the instruction EX holds and unbounded event tallies.
    exrec_t m_ex = '0;
    int     m_stalls = 0;
    int     m_flushes = 0;

    function automatic int clip(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic apply(input stim_t s, input string tag);
        bit   depends, lu, pcw;
        cnt_t c;
        @(negedge clk);
        reset = s.reset; hold = s.hold; flush = s.flush; valid_id = s.valid;
        rs_id = s.rs; rt_id = s.rt; rd_id = s.rd; use_rs_id = s.use_rs; use_rt_id = s.use_rt;
        rdata_a_id = s.a; rdata_b_id = s.b; imm_id = s.imm;
        regWrite_id = s.rw; memRead_id = s.mr; memWrite_id = s.mw;
        memToReg_id = s.m2r; aluSrc_id = s.asrc; aluOp_id = s.op;

        depends = (s.use_rs && s.rs == m_ex.rd) || (s.use_rt && s.rt == m_ex.rd);
        lu  = m_ex.v && m_ex.mr && (m_ex.rd != 0) && s.valid && depends;
        pcw = !(lu && !s.flush) && !s.hold;
        q_pcw.push_back(pcw);
        q_ctag.push_back(tag);

        if (s.reset) begin
            m_ex = '0; m_stalls = 0; m_flushes = 0;
        end else if (s.hold) begin
            // nothing moves
        end else if (s.flush) begin
            m_ex = '0; m_flushes++;
        end else if (lu) begin
            m_ex = '0; m_stalls++;
        end else begin
            m_ex = '{rs: s.rs, rt: s.rt, rd: s.rd, a: s.a, b: s.b, imm: s.imm,
                     rw: s.rw, mr: s.mr, mw: s.mw, m2r: s.m2r, asrc: s.asrc,
                     op: s.op, v: s.valid};
        end
        c.sc  = CW'(clip(m_stalls, (1 << CW) - 1));
        c.fc  = CW'(clip(m_flushes, (1 << CW) - 1));
        c.sc2 = CWS'(clip(m_stalls, (1 << CWS) - 1));
        c.fc2 = CWS'(clip(m_flushes, (1 << CWS) - 1));
        q_ex.push_back(m_ex);
        q_cnt.push_back(c);
        q_tag.push_back(tag);
    endtask

    function automatic stim_t ins(input logic v, input int rs, input int rt, input int rd,
                                  input logic urs, input logic urt, input logic rw, input logic mr);
        stim_t s;
        s = '0;
        s.valid = v; s.rs = AW'(rs); s.rt = AW'(rt); s.rd = AW'(rd);
        s.use_rs = urs; s.use_rt = urt; s.rw = rw; s.mr = mr;
        s.m2r = mr; s.asrc = mr;
        s.op = mr ? OW'(ALU_ADD) : OW'($urandom_range(0, 11));
        s.a = DW'($urandom); s.b = DW'($urandom); s.imm = DW'($urandom);
        return s;
    endfunction

    // Registered-output monitor: one expectation per clock edge.
    always @(posedge clk) begin
        exrec_t e, act;
        cnt_t   ec, ac;
        string  t;
        #1;
        if (q_ex.size() > 0) begin
            e  = q_ex.pop_front();
            ec = q_cnt.pop_front();
            t  = q_tag.pop_front();
            act = '{rs: rs_ex, rt: rt_ex, rd: rd_ex, a: rdata_a_ex, b: rdata_b_ex, imm: imm_ex,
                    rw: regWrite_ex, mr: memRead_ex, mw: memWrite_ex, m2r: memToReg_ex,
                    asrc: aluSrc_ex, op: aluOp_ex, v: valid_ex};
            ac = '{sc: stall_cnt, fc: flush_cnt, sc2: s_stall_cnt, fc2: s_flush_cnt};
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL ex_regs[%s] t=%0t got %h required %h", t, $time, act, e);
            n_checks++;
            if (ac === ec) n_pass++;
            else $display("FAIL counters[%s] t=%0t got %h required %h", t, $time, ac, ec);
        end
    end

    // Write-enable monitor: sampled mid-cycle after the driver has settled the inputs.
    always @(negedge clk) begin
        logic  e;
        string t;
        #2;
        if (q_pcw.size() > 0) begin
            e = q_pcw.pop_front();
            t = q_ctag.pop_front();
            n_checks++;
            if (pc_write === e && if_id_write === e && s_pc_write === e) n_pass++;
            else $display("FAIL pc_write[%s] t=%0t got pc=%b ifid=%b required %b",
                          t, $time, pc_write, if_id_write, e);
        end
    end

    initial begin
        stim_t s, dep;
        reset = 1'b1; hold = 1'b1; flush = 1'b0; valid_id = 1'b0;
        rs_id = '0; rt_id = '0; rd_id = '0; use_rs_id = 1'b0; use_rt_id = 1'b0;
        rdata_a_id = '0; rdata_b_id = '0; imm_id = '0;
        regWrite_id = 1'b0; memRead_id = 1'b0; memWrite_id = 1'b0;
        memToReg_id = 1'b0; aluSrc_id = 1'b0; aluOp_id = '0;

        // Reset wins over hold
        s = ins(1, 1, 2, 3, 1, 1, 1, 0); s.reset = 1; s.hold = 1;
        apply(s, "reset_hold");
        s = ins(0, 0, 0, 0, 0, 0, 0, 0); s.reset = 1;
        apply(s, "reset");

        // add $3,$1,$2
        apply(ins(1, 1, 2, 3, 1, 1, 1, 0), "normal_add");

        // lw $5 then add $6,$5,$1: one bubble, then the add goes through
        apply(ins(1, 4, 5, 5, 1, 0, 1, 1), "lw5");
        dep = ins(1, 5, 1, 6, 1, 1, 1, 0);
        apply(dep, "loaduse_stall");
        apply(dep, "loaduse_release");

        // lw $0 then use of $0
        apply(ins(1, 4, 0, 0, 1, 0, 1, 1), "lw0");
        apply(ins(1, 0, 0, 8, 1, 1, 1, 0), "use_r0");

        // lw $7 then rt=7 unused
        apply(ins(1, 4, 7, 7, 1, 0, 1, 1), "lw7");
        apply(ins(1, 2, 7, 9, 1, 0, 1, 0), "rt_unused");

        // flush and load-use together
        apply(ins(1, 4, 9, 9, 1, 0, 1, 1), "lw9");
        s = ins(1, 9, 9, 10, 1, 1, 1, 0); s.flush = 1;
        apply(s, "flush_and_lu");

        // hold three cycles mid-stream
        apply(ins(1, 1, 2, 11, 1, 1, 1, 0), "pre_hold");
        s = ins(1, 3, 4, 12, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            s.hold = 1;
            apply(s, "hold");
        end
        s.hold = 0;
        apply(s, "hold_release");

        // reset during a stall
        apply(ins(1, 4, 10, 10, 1, 0, 1, 1), "lw10");
        s = ins(1, 10, 1, 13, 1, 1, 1, 0); s.reset = 1;
        apply(s, "reset_in_stall");
        apply(ins(1, 10, 1, 13, 1, 1, 1, 0), "after_reset");

        // repeated stalls: the 2-bit counter pins at its maximum
        for (int i = 0; i < 5; i++) begin
            apply(ins(1, 4, 11, 11, 1, 0, 1, 1), "sat_lw");
            apply(ins(1, 1, 11, 14, 1, 1, 1, 0), "sat_stall");
        end
        for (int i = 0; i < 5; i++) begin
            s = ins(1, 1, 2, 3, 1, 1, 1, 0); s.flush = 1;
            apply(s, "sat_flush");
        end

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            s = ins(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), ($urandom_range(0, 9) < 4));
            s.mw    = $urandom_range(0, 1);
            s.flush = ($urandom_range(0, 19) == 0);
            s.hold  = ($urandom_range(0, 11) == 0);
            s.reset = ($urandom_range(0, 99) == 0);
            apply(s, "random");
        end

        for (int i = 0; i < 10 && (q_ex.size() > 0 || q_pcw.size() > 0); i++)
            @(posedge clk);
        #3;
        if (q_ex.size() > 0 || q_pcw.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d required 0", q_ex.size() + q_pcw.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID and presents rs_ex, rt_ex, rd_ex and the EX/MEM/WB control bits to the EX stage and the forwarding unit.
- Inserts a one-cycle bubble when an instruction depends on a load currently in EX, and stalls PC and IF/ID during that cycle.
- Keeps a saturating stall/flush event counter for performance debug.

Parameters:
- DATA_W, 32, width of register operands and immediate.
- REG_AW, 5, register-index width.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  global freeze (e.g. memory busy); all state keeps its value.
- flush  in  1  branch/jump resolved taken; kill the instruction entering EX.
- valid_id  in  1  ID holds a real instruction.
- rs_id, rt_id, rd_id  in  REG_AW each  source and destination indices (rd_id is already muxed to rt/rd/31).
- use_rs_id, use_rt_id  in  1 each  instruction actually reads rs/rt.
- rdata_a_id, rdata_b_id, imm_id  in  DATA_W each  register file data and sign-extended immediate.
- regWrite_id, memRead_id, memWrite_id, memToReg_id, aluSrc_id  in  1 each  control bits.
- aluOp_id  in  ALUOP_W  ALU op.
- rs_ex, rt_ex, rd_ex  out  REG_AW each  registered indices.
- rdata_a_ex, rdata_b_ex, imm_ex  out  DATA_W each  registered data.
- regWrite_ex, memRead_ex, memWrite_ex, memToReg_ex, aluSrc_ex  out  1 each  registered control.
- aluOp_ex  out  ALUOP_W  registered ALU op.
- valid_ex  out  1  EX holds a real instruction.
- pc_write  out  1  combinational; 0 freezes the PC.
- if_id_write  out  1  combinational; 0 freezes the IF/ID register.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset: every registered output is 0 (bubble = NOP: valid_ex=0, all control 0, all data and indices 0), and both counters are 0. Reset overrides hold.
- Hazard, combinational: load_use = valid_ex & memRead_ex & (rd_ex != 0) & valid_id & ((use_rs_id & rs_id == rd_ex) | (use_rt_id & rt_id == rd_ex)).
- pc_write = if_id_write = ~(load_use & ~flush) & ~hold.
- Per-edge priority:
  1. reset
  2. hold: all registers keep their value and the counters do not change
  3. flush: load the bubble, flush_cnt += 1
  4. load_use: load the bubble, stall_cnt += 1
  5. otherwise: load all *_id fields; valid_ex = valid_id.
- Bubble content: valid_ex=0; regWrite, memRead, memWrite, memToReg, aluSrc = 0; aluOp=0; rs, rt, rd = 0.
  - Zeroed indices guarantee the forwarding unit never matches on a bubble.
  - Data fields are don't-care; drive them to 0.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble. On the next cycle rd_ex is no longer the load, so the stall releases automatically.
- Flush and load_use in the same cycle: flush wins and the stall is not asserted, because the ID instruction is itself being killed upstream. Only flush_cnt increments.
- Counters saturate at all-ones and do not wrap.
- A dependency on $0 never stalls.
- An invalid ID slot (valid_id=0) never stalls and is propagated with valid_ex=0, so its control bits are captured as-is but are inert.
- Reset during a stall clears the stall on the same edge; pc_write returns to 1 once reset is deasserted.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW, DATA_W, ALUOP_W
  - the ALU op encodings
  - a packed ex_ctrl_t struct {regWrite, memRead, memWrite, memToReg, aluSrc, aluOp}
  - the constant EX_CTRL_NOP = 0.
- One sub-module, hazard_detect: purely combinational. It computes load_use, pc_write and if_id_write, and can be tested in isolation.
- The register and counter logic stays in id_ex_stage.

Test Plan:
- Normal flow: issue add $3,$1,$2 (rs=1, rt=2, rd=3, regWrite=1) with no hazard -> next cycle rs_ex=1, rt_ex=2, rd_ex=3, regWrite_ex=1, valid_ex=1; pc_write stays 1.
- Load-use: EX holds lw $5 (memRead_ex=1, rd_ex=5); ID has add $6,$5,$1 with use_rs=1 -> pc_write=0, if_id_write=0 that cycle; next edge gives valid_ex=0 and stall_cnt=1; the following edge gives rs_ex=5 with no stall.
- $0 and unused operand: lw $0 followed by a use of $0 -> no stall. lw $7 followed by an instruction with rt=7 but use_rt=0 -> no stall.
- Flush plus load_use in the same cycle -> pc_write=1, bubble loaded, flush_cnt=1, stall_cnt=0.
- Hold: set hold=1 for 3 cycles mid-stream -> outputs and counters unchanged, pc_write=0; on release the pipeline resumes with the held instruction.
- Saturation and reset: preload stall_cnt to 0xFFFF, then cause a stall -> stays 0xFFFF. Assert reset during a stall -> all outputs 0 after the edge.
